// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Package     : chip8_pkg
// Description : Shared definitions for the Chip-8 work-RAM arbitration slice:
//               RAM address width, the 2-bit RAM owner encoding and the
//               ownership FSM state encoding, plus a state-to-owner helper.
// Revision    : 1.0 - initial release
// ============================================================================
package chip8_pkg;

  localparam int CHIP8_RAM_ADDR_W = 12;

  // Which master drives the RAM port (also used as the read-return tag).
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_BLT  = 2'd3
  } owner_t;

  // Ownership FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_LD  = 2'd1,
    ST_OWN_CPU = 2'd2,
    ST_OWN_BLT = 2'd3
  } arb_state_t;

  function automatic owner_t state_owner(input arb_state_t st);
    owner_t o;
    case (st)
      ST_OWN_LD:  o = OWN_LD;
      ST_OWN_CPU: o = OWN_CPU;
      ST_OWN_BLT: o = OWN_BLT;
      default:    o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage : chip8_pkg
`default_nettype wire

// File: rtl/ram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ram_rd_tag_pipe
// Description : READ_LAT-deep shift register of read owner tags. A tag enters
//               on every granted read and leaves READ_LAT cycles later, just
//               as the RAM presents the data, where it is decoded into one
//               rvalid strobe per master. Sync clear drops in-flight reads.
// Ports       : clk, reset     - clock, synchronous active-high clear
//               tag_in         - owner of the read issued this cycle (or NONE)
//               ld_rvalid      - loader read data on ram_out this cycle
//               cpu_rvalid     - CPU read data on ram_out this cycle
//               blt_rvalid     - blitter read data on ram_out this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rd_tag_pipe
  import chip8_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  owner_t tag_in,
  output logic   ld_rvalid,
  output logic   cpu_rvalid,
  output logic   blt_rvalid
);

  owner_t pipe [READ_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= OWN_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign ld_rvalid  = (pipe[READ_LAT-1] == OWN_LD);
  assign cpu_rvalid = (pipe[READ_LAT-1] == OWN_CPU);
  assign blt_rvalid = (pipe[READ_LAT-1] == OWN_BLT);

endmodule : ram_rd_tag_pipe
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares the single-port Chip-8 work RAM between the ROM loader,
//               the CPU and the blitter (read-only sprite fetch). Registered
//               ownership FSM: loader has absolute priority (but only takes
//               over at a burst boundary), CPU/blitter alternate round-robin,
//               and a non-loader owner is preempted after MAX_BURST granted
//               cycles when someone else is waiting.
// Ports       : clk, reset                     - clock, sync active-high reset
//               ld_en/wr/addr/wdata, ld_gnt, ld_rvalid     - loader master
//               cpu_en/wr/addr/wdata, cpu_gnt, cpu_rvalid  - CPU master
//               blt_en/addr, blt_gnt, blt_rvalid           - blitter master
//               rdata                          - ram_out broadcast
//               ram_en/wr/addr/in, ram_out     - RAM macro port
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import chip8_pkg::*;
#(
  parameter int ADDR_W    = CHIP8_RAM_ADDR_W,
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  input  logic              cpu_en,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              blt_en,
  input  logic [ADDR_W-1:0] blt_addr,
  output logic              blt_gnt,
  output logic              blt_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int                CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt, pick;
  owner_t           last_owner, last_owner_nxt;
  owner_t           cur_owner, rd_tag;
  logic [CNT_W-1:0] burst_cnt;
  logic             own_en, others_req, burst_done;

  // Owner's request and whether anybody else is waiting.
  always_comb begin
    own_en     = 1'b0;
    others_req = 1'b0;
    case (state)
      ST_OWN_LD:  begin own_en = ld_en;  others_req = cpu_en | blt_en; end
      ST_OWN_CPU: begin own_en = cpu_en; others_req = ld_en  | blt_en; end
      ST_OWN_BLT: begin own_en = blt_en; others_req = ld_en  | cpu_en; end
      default:    begin end
    endcase
  end

  // Arbitration winner: loader first, then round-robin between CPU/blitter.
  always_comb begin
    if (ld_en)                  pick = ST_OWN_LD;
    else if (cpu_en && blt_en)  pick = (last_owner == OWN_CPU) ? ST_OWN_BLT : ST_OWN_CPU;
    else if (cpu_en)            pick = ST_OWN_CPU;
    else if (blt_en)            pick = ST_OWN_BLT;
    else                        pick = ST_IDLE;
  end

  // The loader is never preempted; CPU/blitter yield at the burst boundary.
  assign burst_done = ((state == ST_OWN_CPU) || (state == ST_OWN_BLT)) &&
                      (burst_cnt == BURST_LAST) && others_req;

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    if ((state == ST_IDLE) || !own_en) begin
      // Owner gone (or none): hand over directly on this edge.
      state_nxt = pick;
    end else if (burst_done) begin
      // Preempted owner was still issuing this cycle, so insert the bubble.
      state_nxt = ST_IDLE;
    end
    if (state_nxt != state) begin
      if (state_nxt == ST_OWN_CPU)      last_owner_nxt = OWN_CPU;
      else if (state_nxt == ST_OWN_BLT) last_owner_nxt = OWN_BLT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= OWN_BLT;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      // Saturates so a lone owner becomes preemptible as soon as anyone asks.
      if ((state_nxt != state) || (state == ST_IDLE))
        burst_cnt <= '0;
      else if (burst_cnt != BURST_LAST)
        burst_cnt <= burst_cnt + 1'b1;
    end
  end

  assign ld_gnt  = (state == ST_OWN_LD);
  assign cpu_gnt = (state == ST_OWN_CPU);
  assign blt_gnt = (state == ST_OWN_BLT);

  // Access issue straight from the owner's level interface.
  always_comb begin
    ram_en    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_in    = '0;
    cur_owner = state_owner(state);
    case (state)
      ST_OWN_LD: begin
        ram_en   = ld_en;
        ram_wr   = ld_en & ld_wr;
        ram_addr = ld_addr;
        ram_in   = ld_wdata;
      end
      ST_OWN_CPU: begin
        ram_en   = cpu_en;
        ram_wr   = cpu_en & cpu_wr;
        ram_addr = cpu_addr;
        ram_in   = cpu_wdata;
      end
      ST_OWN_BLT: begin
        ram_en   = blt_en;
        ram_addr = blt_addr;
      end
      default: begin end
    endcase
  end

  assign rd_tag = (ram_en && !ram_wr) ? cur_owner : OWN_NONE;

  ram_rd_tag_pipe #(
    .READ_LAT (READ_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .tag_in     (rd_tag),
    .ld_rvalid  (ld_rvalid),
    .cpu_rvalid (cpu_rvalid),
    .blt_rvalid (blt_rvalid)
  );

  assign rdata = ram_out;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Bench for ram_arbiter. A RAM macro model sits on the RAM port;
//               a behavioural ownership model with a reference memory and a
//               queue of expected read returns predicts every output each
//               cycle. Directed scenarios carry literal expectations, then a
//               randomized phase exercises all three masters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int READ_LAT  = 1;
  localparam int MAX_BURST = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_en, ld_wr, cpu_en, cpu_wr, blt_en;
  logic [ADDR_W-1:0] ld_addr, cpu_addr, blt_addr, ram_addr;
  logic [DATA_W-1:0] ld_wdata, cpu_wdata, rdata, ram_in, ram_out;
  logic              ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, blt_gnt, blt_rvalid;
  logic              ram_en, ram_wr;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_en(ld_en), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .blt_en(blt_en), .blt_addr(blt_addr), .blt_gnt(blt_gnt), .blt_rvalid(blt_rvalid),
    .rdata(rdata),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_in(ram_in),
    .ram_out(ram_out)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7 + 3) & 8'hFF);
  endfunction

  // RAM macro, 1-cycle read latency; contents preloaded on the first edge.
  logic [7:0] ram [4096];
  logic       ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int a = 0; a < 4096; a++) ram[a] <= init_val(a);
      ram_loaded <= 1'b1;
    end else if (ram_en === 1'b1) begin
      if (ram_wr === 1'b1) ram[ram_addr] <= ram_in;
      else                 ram_out       <= ram[ram_addr];
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner ids: 0 none, 1 loader, 2 cpu, 3 blitter.
  typedef struct {
    int         due;
    int         who;
    logic [7:0] data;
  } ret_t;

  bit         run      = 1'b0;
  bit         ref_init = 1'b0;
  logic [7:0] ref_mem [4096];
  ret_t       pend [$];
  int         m_own  = 0;
  int         m_held = 0;   // granted cycles of the current owner so far
  int         m_last = 3;   // most recent of CPU/blitter to gain ownership
  bit         m_iss [4];    // master k issued an access in the last cycle

  function automatic int winner(input bit l, input bit c, input bit b, input int last);
    if (l)      return 1;
    if (c && b) return (last == 2) ? 3 : 2;
    if (c)      return 2;
    if (b)      return 3;
    return 0;
  endfunction

  always @(negedge clk) begin : p_cmp
    bit         req [4];
    bit         e_en, e_wr, op_wr, others;
    logic [11:0] m_a;
    logic [7:0]  m_d, e_rd;
    int         who_ret, n_new;
    if (!ref_init) begin
      for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(a);
      ref_init = 1'b1;
    end
    if (run) begin
      req[0] = 1'b0; req[1] = ld_en; req[2] = cpu_en; req[3] = blt_en;
      who_ret = 0;
      e_rd    = 8'h00;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        who_ret = pend[0].who;
        e_rd    = pend[0].data;
        void'(pend.pop_front());
      end
      op_wr = 1'b0; m_a = 12'h000; m_d = 8'h00;
      case (m_own)
        1: begin op_wr = ld_wr;  m_a = ld_addr;  m_d = ld_wdata;  end
        2: begin op_wr = cpu_wr; m_a = cpu_addr; m_d = cpu_wdata; end
        3: begin op_wr = 1'b0;   m_a = blt_addr; end
        default: begin end
      endcase
      e_en = (m_own != 0) && req[m_own];
      e_wr = e_en && op_wr;

      chk("ld_gnt",     ld_gnt,     m_own == 1);
      chk("cpu_gnt",    cpu_gnt,    m_own == 2);
      chk("blt_gnt",    blt_gnt,    m_own == 3);
      chk("ld_rvalid",  ld_rvalid,  who_ret == 1);
      chk("cpu_rvalid", cpu_rvalid, who_ret == 2);
      chk("blt_rvalid", blt_rvalid, who_ret == 3);
      chk("ram_en",     ram_en,     e_en);
      chk("ram_wr",     ram_wr,     e_wr);
      if (e_en)        chk("ram_addr", ram_addr, m_a);
      if (e_wr)        chk("ram_in",   ram_in,   m_d);
      if (who_ret != 0) chk("rdata",   rdata,    e_rd);

      for (int k = 0; k < 4; k++) m_iss[k] = e_en && (m_own == k);
      if (e_en && !e_wr && !reset) pend.push_back('{cyc + READ_LAT, m_own, ref_mem[m_a]});
      if (e_wr) ref_mem[m_a] = m_d;

      if (reset) begin
        pend.delete();
        m_own = 0; m_held = 0; m_last = 3;
      end else begin
        others = 1'b0;
        for (int k = 1; k < 4; k++) if (k != m_own && req[k]) others = 1'b1;
        n_new = m_own;
        if (m_own == 0 || !req[m_own])
          n_new = winner(req[1], req[2], req[3], m_last);
        else if (m_own != 1 && m_held >= MAX_BURST - 1 && others)
          n_new = 0;
        if (n_new != m_own) begin
          m_held = 0;
          if (n_new >= 2) m_last = n_new;
        end else if (m_own != 0) begin
          m_held++;
        end
        m_own = n_new;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] blt_lit [5];
  int         cnt;

  initial begin
    blt_lit[0] = 8'h63; blt_lit[1] = 8'h6A; blt_lit[2] = 8'h71;
    blt_lit[3] = 8'h78; blt_lit[4] = 8'h7F;
    reset = 1'b1;
    ld_en = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_wdata = '0;
    cpu_en = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    blt_en = 1'b0; blt_addr = '0;
    tick(); tick();
    run = 1'b1;
    chk("rst_ld_gnt", ld_gnt, 1'b0);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_blt_gnt", blt_gnt, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_rvalids", {ld_rvalid, cpu_rvalid, blt_rvalid}, 3'b000);
    reset = 1'b0;
    tick();

    // Single CPU read of 0x200.
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h200;
    tick();
    chk("t1_cpu_gnt", cpu_gnt, 1'b1);
    chk("t1_ram_addr", ram_addr, 12'h200);
    tick();
    chk("t1_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("t1_rdata", rdata, 8'h03);
    cpu_en = 1'b0;
    tick();

    // CPU and blitter request together with last_owner = BLT.
    reset = 1'b1; tick(); reset = 1'b0;
    cpu_en = 1'b1; cpu_addr = 12'h210; blt_en = 1'b1; blt_addr = 12'h1A0;
    tick();
    chk("t2_cpu_first", {cpu_gnt, blt_gnt}, 2'b10);
    cpu_en = 1'b0;
    tick();
    chk("t2_blt_gnt", blt_gnt, 1'b1);
    chk("t2_blt_addr", ram_addr, 12'h1A0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_blt_rvalid", blt_rvalid, 1'b1);
      chk("t2_blt_rdata", rdata, blt_lit[i]);
      if (i < 4) blt_addr = 12'h1A1 + 12'(i);
      else       blt_en = 1'b0;
    end
    tick();

    // CPU burst limit with blitter waiting.
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h210; blt_en = 1'b1; blt_addr = 12'h1B0;
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (cpu_gnt === 1'b1) cnt++;
    end
    chk("t3_cpu_burst_len", cnt, 16);
    chk("t3_bubble", {cpu_gnt, blt_gnt}, 2'b00);
    tick();
    chk("t3_blt_after_bubble", blt_gnt, 1'b1);
    cpu_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (blt_gnt === 1'b1) cnt++;
    end
    chk("t3_blt_keeps", cnt, 25);
    blt_en = 1'b0;
    tick(); tick();

    // Loader block write with CPU waiting.
    ld_en = 1'b1; ld_wr = 1'b1; ld_addr = 12'h200; ld_wdata = 8'h5A;
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h200;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (cpu_gnt !== 1'b0) cnt++;
      ld_addr  = 12'h200 + 12'(i);
      ld_wdata = 8'(i) ^ 8'h5A;
    end
    tick();
    if (cpu_gnt !== 1'b0) cnt++;
    ld_en = 1'b0;
    chk("t4_cpu_blocked", cnt, 0);
    tick();
    chk("t4_cpu_gnt", cpu_gnt, 1'b1);
    tick();
    chk("t4_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("t4_loaded_byte", rdata, 8'h5A);
    cpu_en = 1'b0;
    tick();

    // Reset while the blitter owns with a read in flight.
    blt_en = 1'b1; blt_addr = 12'h1A0;
    tick();
    chk("t5_blt_gnt", blt_gnt, 1'b1);
    reset = 1'b1;
    tick();
    chk("t5_gnts", {ld_gnt, cpu_gnt, blt_gnt}, 3'b000);
    chk("t5_rvalids", {ld_rvalid, cpu_rvalid, blt_rvalid}, 3'b000);
    chk("t5_idle_no_issue", ram_en, 1'b0);
    reset = 1'b0; blt_en = 1'b0;
    tick();
    chk("t5_no_stale", blt_rvalid, 1'b0);

    // CPU writes in its last burst cycle; blitter then reads it back.
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h301; blt_en = 1'b1; blt_addr = 12'h300;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 16) begin
        cpu_wr = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'hA5;
      end
    end
    tick();
    chk("t6_cpu_preempted", cpu_gnt, 1'b0);
    cpu_en = 1'b0; cpu_wr = 1'b0;
    tick();
    chk("t6_blt_gnt", blt_gnt, 1'b1);
    tick();
    chk("t6_blt_rvalid", blt_rvalid, 1'b1);
    chk("t6_readback", rdata, 8'hA5);
    blt_en = 1'b0;
    tick();

    // Randomized traffic; masters hold their request until it is issued.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (ld_en) begin
        if (m_iss[1]) begin
          if ($urandom_range(0, 5) == 0) ld_en = 1'b0;
          else begin
            ld_wr = ($urandom_range(0, 3) != 0);
            ld_addr = 12'h300 + 12'($urandom_range(0, 15));
            ld_wdata = 8'($urandom);
          end
        end
      end else if ($urandom_range(0, 59) == 0) begin
        ld_en = 1'b1; ld_wr = ($urandom_range(0, 3) != 0);
        ld_addr = 12'h300 + 12'($urandom_range(0, 15)); ld_wdata = 8'($urandom);
      end
      if (cpu_en) begin
        if (m_iss[2]) begin
          if ($urandom_range(0, 19) == 0) cpu_en = 1'b0;
          else begin
            cpu_wr = ($urandom_range(0, 2) == 0);
            cpu_addr = 12'h300 + 12'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        cpu_en = 1'b1; cpu_wr = ($urandom_range(0, 2) == 0);
        cpu_addr = 12'h300 + 12'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      end
      if (blt_en) begin
        if (m_iss[3]) begin
          if ($urandom_range(0, 9) == 0) blt_en = 1'b0;
          else blt_addr = 12'h300 + 12'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 3) == 0) begin
        blt_en = 1'b1; blt_addr = 12'h300 + 12'($urandom_range(0, 15));
      end
      tick();
    end
    reset = 1'b0; ld_en = 1'b0; cpu_en = 1'b0; blt_en = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
